mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum cycles a granted access waits for MemDone before it is aborted (range 2..255).
REQ-002 Parameter MAX_DSTREAK, default 3: consecutive data grants allowed while an instruction request is pending (range 1..7).
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 IReq  in  1  fetch-stage read request, held until IReady.
REQ-006 IAddr  in  32  fetch address, stable while IReq is high.
REQ-007 IReady  out  1  one-cycle completion pulse to fetch.
REQ-008 IRData  out  32  read data for fetch, valid when IReady is high.
REQ-009 DReq  in  1  memory-stage request, held until DReady.
REQ-010 DWe  in  1  1 = write, 0 = read; stable while DReq is high.
REQ-011 DAddr, DWData  in  32 each  data address and write data.
REQ-012 DReady  out  1  one-cycle completion pulse to the memory stage.
REQ-013 DRData  out  32  read data, valid when DReady is high.
REQ-014 Err  out  1  pulses together with IReady or DReady when the access timed out.
REQ-015 MemReq, MemWe  out  1 each  shared single-port memory request and write enable (registered).
REQ-016 MemAddr, MemWData  out  32 each  registered memory address and write data.
REQ-017 MemDone  in  1  memory completion pulse, with MemRData valid.
REQ-018 MemRData  in  32  memory read data.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, BUSY_D and BUSY_I.
REQ-020 IDLE with DReq=1: the FSM SHALL go to BUSY_D at the next edge, unless the instruction side takes priority under REQ-022.
REQ-021 IDLE with DReq=0 and IReq=1: the FSM SHALL go to BUSY_I.
REQ-022 IDLE with both requests high and DStreak==MAX_DSTREAK: the FSM SHALL go to BUSY_I.
REQ-023 On the grant edge, MemAddr, MemWe and MemWData SHALL be captured from the granted requester, and MemReq SHALL be set to 1.
  - Fetch grants capture MemWe=0.
  - Latency from Req to MemReq is 1 cycle.
REQ-024 While in BUSY_x, the Mem* outputs SHALL stay constant.
REQ-025 BUSY_x with MemDone=1: Ready_x SHALL be 1 in that same cycle (combinational), with x_RData = MemRData.
  - At the next edge: state goes to IDLE and MemReq clears.
  - A mandatory one-cycle IDLE bubble follows every access.
REQ-026 The non-granted Ready output and RData bus SHALL be 0.
REQ-027 DStreak (3 bits) SHALL update as follows:
  - increments on each data grant made while IReq=1;
  - clears on every instruction grant;
  - clears on any data grant with IReq=0;
  - never exceeds MAX_DSTREAK.
REQ-028 The watchdog count SHALL clear on each grant and increment each cycle spent in BUSY_x.
REQ-029 When the count reaches MEM_TIMEOUT with MemDone=0, the block SHALL:
  - pulse Ready_x and Err for one cycle with x_RData = 0;
  - return to IDLE at the next edge with MemReq = 0.
REQ-030 MemDone in the same cycle as timeout SHALL count as a normal completion, with Err=0.
REQ-031 MemDone while in IDLE SHALL be ignored.
REQ-032 A requester dropping Req before Ready SHALL NOT abort an access already granted.

Reset
REQ-033 On reset assertion the block SHALL asynchronously force:
  - state = IDLE, DStreak = 0, watchdog = 0;
  - MemReq = MemWe = 0, MemAddr = MemWData = 0;
  - IReady = DReady = Err = 0.
REQ-034 Reset during BUSY_x SHALL abandon the access with no Ready pulse.
REQ-035 After reset deassertion, the first grant SHALL occur no earlier than the first rising edge.

Structure
REQ-036 A shared package SHALL hold the state encoding (IDLE=2'b00, BUSY_D=2'b01, BUSY_I=2'b10) and the default values of MEM_TIMEOUT and MAX_DSTREAK.
REQ-037 The watchdog SHALL be a separate sub-module, mem_wdog, with inputs clk, reset, clear and run, and a one-bit expired output.
REQ-038 Arbitration, the DStreak counter and the output muxing SHALL remain in mem_port_arbiter.

Verification
REQ-039 IReq=1 alone at 0x100, MemDone 3 cycles after MemReq with MemRData=0xE3A00001 -> MemReq at cycle 1, IReady=1 and IRData=0xE3A00001 at cycle 4, MemReq=0 at cycle 5.
REQ-040 IReq and DReq (DWe=1, DAddr=0x200, DWData=0xAB) rise together -> data granted first, MemWe=1 and MemWData=0xAB, then fetch granted after the IDLE bubble.
REQ-041 IReq held while DReq is re-raised continuously, MAX_DSTREAK=3 -> grant order D, D, D, I, D.
REQ-042 MemDone never arrives, MEM_TIMEOUT=15 -> DReady=1, Err=1 and DRData=0 in the 15th cycle after the grant, then state IDLE and MemReq=0.
REQ-043 MemDone in the exact timeout cycle -> Ready=1, Err=0, RData=MemRData.
REQ-044 Reset asserted mid-cycle during BUSY_D -> MemReq drops before the next edge, no DReady pulse, and DStreak reads 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int MEM_TIMEOUT_DEF = 15;
  localparam int MAX_DSTREAK_DEF = 3;

  typedef logic [31:0] word_t;
  typedef logic [2:0]  streak_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_D = 2'b01,
    BUSY_I = 2'b10
  } arb_state_e;

  // Saturating increment so the data streak can never pass its limit.
  function automatic streak_t streak_inc(streak_t cur, streak_t lim);
    return (cur >= lim) ? lim : cur + 3'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and shared-memory signals seen by the arbiter.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic  IReq;
  word_t IAddr;
  logic  IReady;
  word_t IRData;

  logic  DReq;
  logic  DWe;
  word_t DAddr;
  word_t DWData;
  logic  DReady;
  word_t DRData;

  logic  Err;

  logic  MemReq;
  logic  MemWe;
  word_t MemAddr;
  word_t MemWData;
  logic  MemDone;
  word_t MemRData;

  modport slave (
    input  IReq, IAddr, DReq, DWe, DAddr, DWData, MemDone, MemRData,
    output IReady, IRData, DReady, DRData, Err,
           MemReq, MemWe, MemAddr, MemWData
  );

  modport master (
    output IReq, IAddr, DReq, DWe, DAddr, DWData, MemDone, MemRData,
    input  IReady, IRData, DReady, DRData, Err,
           MemReq, MemWe, MemAddr, MemWData
  );

endinterface

// File: rtl/mem_wdog.sv
// Access watchdog: counts busy cycles since the last grant and flags the
// cycle in which the running count reaches TIMEOUT.
module mem_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count_q;

  // count_q holds the number of busy cycles already completed, so the
  // current busy cycle is number count_q + 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (run && !expired) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired = run && (count_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory with
// data priority, an anti-starvation streak limit and an access watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int MAX_DSTREAK = MAX_DSTREAK_DEF
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam streak_t STREAK_MAX = streak_t'(MAX_DSTREAK);

  arb_state_e state_q;
  streak_t    dstreak_q;
  streak_t    dstreak_d;
  logic       mem_req_q;
  logic       mem_we_q;
  word_t      mem_addr_q;
  word_t      mem_wdata_q;

  logic busy;
  logic expired;
  logic grant_i;
  logic grant_d;
  logic finish;

  assign busy = (state_q == BUSY_D) || (state_q == BUSY_I);

  // Data wins unless it has already starved a waiting fetch for the full streak.
  assign grant_i = (state_q == IDLE) && bus.IReq &&
                   (!bus.DReq || (dstreak_q == STREAK_MAX));
  assign grant_d = (state_q == IDLE) && bus.DReq && !grant_i;

  assign finish = busy && (bus.MemDone || expired);

  always_comb begin
    dstreak_d = dstreak_q;
    if (grant_i) begin
      dstreak_d = '0;
    end else if (grant_d) begin
      dstreak_d = bus.IReq ? streak_inc(dstreak_q, STREAK_MAX) : '0;
    end
  end

  mem_wdog #(
    .TIMEOUT(MEM_TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant_i || grant_d),
    .run     (busy),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dstreak_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      dstreak_q <= dstreak_d;
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q     <= BUSY_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.IAddr;
            mem_wdata_q <= '0;
          end else if (grant_d) begin
            state_q     <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.DWe;
            mem_addr_q  <= bus.DAddr;
            mem_wdata_q <= bus.DWData;
          end
        end
        BUSY_D, BUSY_I: begin
          // Requesters dropping Req do not matter here; only completion or timeout ends the access.
          if (finish) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IReady = (state_q == BUSY_I) && finish;
  assign bus.DReady = (state_q == BUSY_D) && finish;
  assign bus.Err    = busy && expired && !bus.MemDone;
  assign bus.IRData = ((state_q == BUSY_I) && bus.MemDone) ? bus.MemRData : '0;
  assign bus.DRData = ((state_q == BUSY_D) && bus.MemDone) ? bus.MemRData : '0;

  assign bus.MemReq   = mem_req_q;
  assign bus.MemWe    = mem_we_q;
  assign bus.MemAddr  = mem_addr_q;
  assign bus.MemWData = mem_wdata_q;

endmodule
